input_spike_encoder: RTL and testbench

Converts the 8-bit input-neuron values held in `input_value_mem` into spike events, one scan per timestep. It sits directly downstream of `input_value_mem`: it drives that memory's read address and consumes its `data_out`. Encoding is deterministic integrate-and-fire: each input neuron has an 8-bit residual, the neuron's value is added every timestep, and a spike is emitted when the sum reaches 256. Spike events go to the first SNN layer over a valid/ready interface.

---
 rtl/snn_input_pkg.sv | 16 +
 rtl/residual_mem.sv | 25 ++
 rtl/input_spike_encoder.sv | 135 +++++++++++++
 tb/tb_input_spike_encoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_input_pkg.sv
// Shared widths, threshold and FSM state encoding for the input spike encoder.
package snn_input_pkg;
    localparam int ADDR_W       = 10;
    localparam int VALUE_W      = 8;
    localparam int STEP_W       = 8;
    localparam int SPIKE_THRESH = 256;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        EMIT,
        ADVANCE,
        DONE
    } enc_state_t;
endpackage

// File: rtl/residual_mem.sv
// Per-neuron residual store: simple dual-port RAM, synchronous write, 1-cycle synchronous read.
module residual_mem #(
    parameter int DEPTH = 1023,
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/input_spike_encoder.sv
// Integrate-and-fire encoder: scans input_value_mem once per timestep and emits valid/ready spike events.
// Optional macro SPIKE_COUNT_EN adds the spike_total handshake counter output.
module input_spike_encoder
    import snn_input_pkg::*;
#(
    parameter int INPUT_NEURON_NUM = 1023,
    parameter int TIMESTEP_NUM     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  mem_addr_out,
    input  logic [VALUE_W-1:0] mem_data_in,
    output logic               spike_valid,
    input  logic               spike_ready,
    output logic [ADDR_W-1:0]  spike_addr,
    output logic [STEP_W-1:0]  spike_step
`ifdef SPIKE_COUNT_EN
    ,
    output logic [15:0]        spike_total
`endif
);
    localparam int RES_AW = (INPUT_NEURON_NUM > 1) ? $clog2(INPUT_NEURON_NUM) : 1;

    enc_state_t         state;
    logic [ADDR_W-1:0]  neuron_idx;
    logic [STEP_W-1:0]  step_idx;
    logic [VALUE_W-1:0] res_q;
    logic [VALUE_W-1:0] res_eff;
    logic [VALUE_W:0]   sum;
    logic               spike;
    logic               last_neuron;
    logic               last_step;

    residual_mem #(
        .DEPTH (INPUT_NEURON_NUM),
        .WIDTH (VALUE_W),
        .AW    (RES_AW)
    ) u_residual_mem (
        .clk     (clk),
        .wr_en   (state == RD_DATA),
        .wr_addr (neuron_idx[RES_AW-1:0]),
        .wr_data (sum[VALUE_W-1:0]),
        .rd_en   (state == RD_ADDR),
        .rd_addr (neuron_idx[RES_AW-1:0]),
        .rd_data (res_q)
    );

    // Step 0 ignores stale residuals, so no clear pass is needed between runs.
    always_comb begin
        res_eff     = (step_idx == '0) ? '0 : res_q;
        sum         = {1'b0, mem_data_in} + {1'b0, res_eff};
        spike       = (sum >= (VALUE_W+1)'(SPIKE_THRESH));
        last_neuron = (neuron_idx == ADDR_W'(INPUT_NEURON_NUM - 1));
        last_step   = (step_idx == STEP_W'(TIMESTEP_NUM - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            neuron_idx   <= '0;
            step_idx     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem_addr_out <= '0;
            spike_valid  <= 1'b0;
            spike_addr   <= '0;
            spike_step   <= '0;
`ifdef SPIKE_COUNT_EN
            spike_total  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RD_ADDR;
                        busy         <= 1'b1;
                        neuron_idx   <= '0;
                        step_idx     <= '0;
                        mem_addr_out <= '0;
`ifdef SPIKE_COUNT_EN
                        spike_total  <= '0;
`endif
                    end
                end
                RD_ADDR: state <= RD_DATA;
                RD_DATA: begin
                    if (spike) begin
                        state       <= EMIT;
                        spike_valid <= 1'b1;
                        spike_addr  <= neuron_idx;
                        spike_step  <= step_idx;
                    end else begin
                        state <= ADVANCE;
                    end
                end
                EMIT: begin
                    if (spike_valid && spike_ready) begin
                        state       <= ADVANCE;
                        spike_valid <= 1'b0;
`ifdef SPIKE_COUNT_EN
                        if (spike_total != '1) begin
                            spike_total <= spike_total + 16'd1;
                        end
`endif
                    end
                end
                ADVANCE: begin
                    if (last_neuron) begin
                        neuron_idx   <= '0;
                        mem_addr_out <= '0;
                        if (last_step) begin
                            step_idx <= '0;
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            step_idx <= step_idx + STEP_W'(1);
                            state    <= RD_ADDR;
                        end
                    end else begin
                        neuron_idx   <= neuron_idx + ADDR_W'(1);
                        mem_addr_out <= neuron_idx + ADDR_W'(1);
                        state        <= RD_ADDR;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_spike_encoder.sv
// Directed and randomized checks of input_spike_encoder against a cumulative-sum spike model (N=4, T=16).
module tb_input_spike_encoder;
    localparam int N = 4;
    localparam int T = 16;
    localparam int BASE_LAT = 3 * N * T + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [9:0] mem_addr_out;
    logic [7:0] mem_data_in = '0;
    logic       spike_valid;
    logic       spike_ready = 1'b1;
    logic [9:0] spike_addr;
    logic [7:0] spike_step;
`ifdef SPIKE_COUNT_EN
    logic [15:0] spike_total;
`endif

    logic [7:0] vals [N];
    int got[$];
    int exp_q[$];
    int valid_cycles = 0;
    int n_cmp = 0;
    int n_bad = 0;

    input_spike_encoder #(
        .INPUT_NEURON_NUM (N),
        .TIMESTEP_NUM     (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .mem_addr_out (mem_addr_out),
        .mem_data_in  (mem_data_in),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .spike_addr   (spike_addr),
        .spike_step   (spike_step)
`ifdef SPIKE_COUNT_EN
        ,
        .spike_total  (spike_total)
`endif
    );

    always #5 clk = ~clk;

    // Model of input_value_mem: registered read, one cycle after the address.
    always @(posedge clk) mem_data_in <= vals[mem_addr_out[1:0]];

    always @(negedge clk) begin
        if (!rst && spike_valid) valid_cycles++;
        if (!rst && spike_valid && spike_ready) got.push_back(int'(spike_addr) * 256 + int'(spike_step));
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Spike at step t iff the running total (t+1)*v crosses a multiple of 256.
    task automatic build_exp();
        exp_q.delete();
        for (int t = 0; t < T; t++)
            for (int n = 0; n < N; n++)
                if (((t + 1) * int'(vals[n])) / 256 != (t * int'(vals[n])) / 256)
                    exp_q.push_back(n * 256 + t);
    endtask

    task automatic compare_events(input string tag);
        int m;
        check({tag, "_count"}, got.size(), exp_q.size());
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++) check({tag, "_event"}, got[i], exp_q[i]);
    endtask

    task automatic compare_counts(input string tag);
        for (int n = 0; n < N; n++) begin
            int c = 0;
            foreach (got[i]) if (got[i] / 256 == n) c++;
            check($sformatf("%s_n%0d", tag, n), c, (T * int'(vals[n])) / 256);
        end
    endtask

    task automatic run(input string tag, input int exp_lat);
        int lat;
        bit seen;
        seen = 1'b0;
        got.delete();
        @(posedge clk); #1 start = 1'b1;
        lat = 1;
        @(posedge clk); #1 start = 1'b0;
        lat = 2;
        @(negedge clk);
        check({tag, "_busy_hi"}, int'(busy), 1);
        for (int i = 0; i < 5000; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
            @(negedge clk);
        end
        check({tag, "_done_lat"}, seen ? lat : -1, exp_lat);
        check({tag, "_busy_lo"}, int'(busy), 0);
    endtask

    initial begin
        vals = '{8'd0, 8'd0, 8'd0, 8'd0};
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(spike_valid), 0);
        check("rst_saddr", int'(spike_addr), 0);
        check("rst_sstep", int'(spike_step), 0);
        check("rst_maddr", int'(mem_addr_out), 0);
        @(negedge clk); rst = 1'b0;

        // Mixed values with a free-flowing consumer.
        vals = '{8'd255, 8'd128, 8'd0, 8'd1};
        build_exp();
        check("a_exp_size", exp_q.size(), 23);
        run("a", BASE_LAT + 23);
        compare_events("a");
        compare_counts("a");
`ifdef SPIKE_COUNT_EN
        check("a_total", int'(spike_total), 23);
`endif

        // All zero: never a spike.
        vals = '{8'd0, 8'd0, 8'd0, 8'd0};
        valid_cycles = 0;
        run("zero", BASE_LAT);
        check("zero_valid", valid_cycles, 0);
`ifdef SPIKE_COUNT_EN
        check("zero_total", int'(spike_total), 0);
`endif

        // Backpressure on the first spike.
        vals = '{8'd255, 8'd0, 8'd0, 8'd0};
        build_exp();
        spike_ready = 1'b0;
        fork
            run("stall", BASE_LAT + 15 + 5);
            begin
                bit found;
                found = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (spike_valid) begin
                        found = 1'b1;
                        break;
                    end
                end
                check("stall_found", int'(found), 1);
                for (int i = 0; i < 6; i++) begin
                    check("stall_valid", int'(spike_valid), 1);
                    check("stall_saddr", int'(spike_addr), 0);
                    check("stall_sstep", int'(spike_step), 1);
                    check("stall_maddr", int'(mem_addr_out), 0);
                    @(posedge clk); #1;
                    if (i == 4) spike_ready = 1'b1;
                    @(negedge clk);
                end
                check("stall_drop", int'(spike_valid), 0);
            end
        join
        compare_events("stall");

        // Random values with a stray start pulse mid-run.
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < N; n++) vals[n] = 8'($urandom_range(0, 255));
            build_exp();
            fork
                run($sformatf("rnd%0d", r), BASE_LAT + exp_q.size());
                begin
                    repeat (20 + $urandom_range(0, 60)) @(posedge clk);
                    #1 start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                end
            join
            compare_events($sformatf("rnd%0d", r));
        end

        // Reset while a step-3 spike is held in EMIT.
        vals = '{8'd255, 8'd128, 8'd0, 8'd1};
        begin
            bit found;
            found = 1'b0;
            spike_ready = 1'b1;
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                if (spike_valid && spike_step == 8'd3) begin
                    spike_ready = 1'b0;
                    found = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            check("rmid_found", int'(found), 1);
            @(negedge clk); #2 rst = 1'b1;
            #1;
            check("rmid_valid", int'(spike_valid), 0);
            check("rmid_busy", int'(busy), 0);
            check("rmid_done", int'(done), 0);
            check("rmid_saddr", int'(spike_addr), 0);
            check("rmid_sstep", int'(spike_step), 0);
            check("rmid_maddr", int'(mem_addr_out), 0);
            @(negedge clk); rst = 1'b0;
            spike_ready = 1'b1;
        end
        build_exp();
        run("rerun", BASE_LAT + 23);
        compare_counts("rerun");
        compare_events("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
